// File: rtl/alu_mdu_pkg.sv
// Shared op-code table, FSM encoding and flag bundle for the ALU/MDU slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_mdu_pkg;

    localparam logic [4:0] OP_ADD    = 5'd0;
    localparam logic [4:0] OP_SUB    = 5'd1;
    localparam logic [4:0] OP_SLL    = 5'd2;
    localparam logic [4:0] OP_SLT    = 5'd3;
    localparam logic [4:0] OP_SLTU   = 5'd4;
    localparam logic [4:0] OP_XOR    = 5'd5;
    localparam logic [4:0] OP_SRL    = 5'd6;
    localparam logic [4:0] OP_SRA    = 5'd7;
    localparam logic [4:0] OP_OR     = 5'd8;
    localparam logic [4:0] OP_AND    = 5'd9;
    localparam logic [4:0] OP_MUL    = 5'd16;
    localparam logic [4:0] OP_MULH   = 5'd17;
    localparam logic [4:0] OP_MULHSU = 5'd18;
    localparam logic [4:0] OP_MULHU  = 5'd19;
    localparam logic [4:0] OP_DIV    = 5'd20;
    localparam logic [4:0] OP_DIVU   = 5'd21;
    localparam logic [4:0] OP_REM    = 5'd22;
    localparam logic [4:0] OP_REMU   = 5'd23;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic zero;
        logic sign;
        logic ovf;
    } flags_t;

    // Codes 16..23 go to the iterative multiply/divide path.
    function automatic logic is_md_op(input logic [4:0] op);
        return (op[4:3] == 2'b10);
    endfunction

endpackage

// File: rtl/alu_core.sv
// Single-cycle integer ALU; unknown op codes pass data1 through.
// Latency: combinational.
// Backpressure: none, output follows inputs.
module alu_core
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] res,
    output logic            ovf
);

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;

    always_comb begin
        shamt = b[SHW-1:0];
        sum   = a + b;
        diff  = a - b;
        res   = a;
        ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                res = sum;
                ovf = (a[XLEN-1] == b[XLEN-1]) && (sum[XLEN-1] != a[XLEN-1]);
            end
            OP_SUB: begin
                res = diff;
                ovf = (a[XLEN-1] != b[XLEN-1]) && (diff[XLEN-1] != a[XLEN-1]);
            end
            OP_SLL:  res = a << shamt;
            OP_SLT:  res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: res = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  res = a ^ b;
            OP_SRL:  res = a >> shamt;
            OP_SRA:  res = XLEN'($signed(a) >>> shamt);
            OP_OR:   res = a | b;
            OP_AND:  res = a & b;
            default: res = a;
        endcase
    end

endmodule

// File: rtl/alu_mdu.sv
// Integer ALU plus iterative shift-add multiplier / restoring divider sharing one accumulator.
// Latency: 1 cycle for ALU, pass-through and divide special cases; XLEN+1 cycles for other mul/div.
// Backpressure: ready_o low while busy; kill_i aborts in-flight work and cancels a same-cycle accept.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] data1_i,
    input  logic [XLEN-1:0] data2_i,
    input  logic            kill_i,
    output logic            ready_o,
    output logic            valid_o,
    output logic [XLEN-1:0] res_o,
    output logic            zero_o,
    output logic            sign_o,
    output logic            ovf_o
);

    localparam int CW = SHW + 1;

    logic [1:0]        state;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   opb_q;
    logic [4:0]        op_q;
    logic              neg_q;
    logic [XLEN-1:0]   pend_res;
    logic [XLEN-1:0]   res_q;
    flags_t            pend_flg;
    flags_t            flg_q;
    flags_t            out_flg;

    logic              accept;
    logic [XLEN-1:0]   alu_res;
    logic              alu_ovf;

    function automatic flags_t mk_flags(input logic [XLEN-1:0] r, input logic o);
        flags_t f;
        f.zero = (r == '0);
        f.sign = r[XLEN-1];
        f.ovf  = o;
        return f;
    endfunction

    alu_core #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_alu_core (
        .op  (op_i),
        .a   (data1_i),
        .b   (data2_i),
        .res (alu_res),
        .ovf (alu_ovf)
    );

    assign ready_o = (state == ST_IDLE);
    assign accept  = valid_i && ready_o && !kill_i;

    // Request-side decode: operand magnitudes, result sign and one-cycle divide cases.
    logic            a_sgn;
    logic            b_sgn;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            neg_req;
    logic            req_md;
    logic            req_div;
    logic            div_zero;
    logic            min_neg1;
    logic            special;
    logic [XLEN-1:0] special_res;
    logic [XLEN-1:0] imm_res;
    logic            imm_ovf;

    always_comb begin
        req_md   = is_md_op(op_i);
        req_div  = req_md && (op_i >= OP_DIV);
        a_sgn    = data1_i[XLEN-1] &&
                   ((op_i == OP_MULH) || (op_i == OP_MULHSU) || (op_i == OP_DIV) || (op_i == OP_REM));
        b_sgn    = data2_i[XLEN-1] &&
                   ((op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM));
        a_mag    = a_sgn ? -data1_i : data1_i;
        b_mag    = b_sgn ? -data2_i : data2_i;
        // Remainder follows the dividend; everything else follows the operand sign product.
        neg_req  = (op_i == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);
        div_zero = (data2_i == '0);
        min_neg1 = ((op_i == OP_DIV) || (op_i == OP_REM)) &&
                   (data1_i == {1'b1, {(XLEN-1){1'b0}}}) && (data2_i == '1);
        special  = req_div && (div_zero || min_neg1);
        if (div_zero) begin
            special_res = op_i[1] ? data1_i : '1;
        end else begin
            special_res = (op_i == OP_DIV) ? data1_i : '0;
        end
        imm_res  = req_md ? special_res : alu_res;
        imm_ovf  = req_md ? 1'b0 : alu_ovf;
    end

    // One iteration step of the shared accumulator, plus the final result pick.
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     rem_diff;
    logic [2*XLEN-1:0] acc_next;
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   md_res;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opb_q} : '0);
        rem_sh   = acc[2*XLEN-1:XLEN-1];
        rem_diff = rem_sh - {1'b0, opb_q};
        if (op_q >= OP_DIV) begin
            acc_next = rem_diff[XLEN] ? {acc[2*XLEN-2:0], 1'b0}
                                      : {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
            acc_next = {mul_sum, acc[XLEN-1:1]};
        end
        prod = neg_q ? -acc_next : acc_next;
        quo  = neg_q ? -acc_next[XLEN-1:0] : acc_next[XLEN-1:0];
        rem  = neg_q ? -acc_next[2*XLEN-1:XLEN] : acc_next[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                      md_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: md_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:             md_res = quo;
            default:                     md_res = rem;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opb_q    <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            pend_res <= '0;
            pend_flg <= mk_flags('0, 1'b0);
            res_q    <= '0;
            flg_q    <= mk_flags('0, 1'b0);
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        op_q <= op_i;
                        if (req_md && !special) begin
                            state <= ST_CALC;
                            cnt   <= CW'(XLEN);
                            acc   <= {{XLEN{1'b0}}, a_mag};
                            opb_q <= b_mag;
                            neg_q <= neg_req;
                        end else begin
                            state    <= ST_DONE;
                            pend_res <= imm_res;
                            pend_flg <= mk_flags(imm_res, imm_ovf);
                        end
                    end
                end
                ST_CALC: begin
                    if (kill_i) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        acc <= acc_next;
                        cnt <= cnt - CW'(1);
                        if (cnt == CW'(1)) begin
                            state    <= ST_DONE;
                            pend_res <= md_res;
                            pend_flg <= mk_flags(md_res, 1'b0);
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    // A killed result is never published; the old one stays on the outputs.
                    if (!kill_i) begin
                        res_q <= pend_res;
                        flg_q <= pend_flg;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign valid_o = (state == ST_DONE) && !kill_i;
    assign out_flg = valid_o ? pend_flg : flg_q;
    assign res_o   = valid_o ? pend_res : res_q;
    assign zero_o  = out_flg.zero;
    assign sign_o  = out_flg.sign;
    assign ovf_o   = out_flg.ovf;

endmodule

// File: tb/tb_alu_mdu.sv
// Directed self-checking bench for alu_mdu at XLEN=32.
// Latency: checks 1-cycle and 33-cycle result timing.
// Backpressure: exercises kill, reset mid-operation and back-to-back requests.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic [4:0]  op_i;
    logic [31:0] data1_i;
    logic [31:0] data2_i;
    logic        kill_i;
    logic        ready_o;
    logic        valid_o;
    logic [31:0] res_o;
    logic        zero_o;
    logic        sign_o;
    logic        ovf_o;

    int errors = 0;
    int checks = 0;

    alu_mdu #(.XLEN(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .op_i    (op_i),
        .data1_i (data1_i),
        .data2_i (data2_i),
        .kill_i  (kill_i),
        .ready_o (ready_o),
        .valid_o (valid_o),
        .res_o   (res_o),
        .zero_o  (zero_o),
        .sign_o  (sign_o),
        .ovf_o   (ovf_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one request, scramble inputs after accept, then wait (bounded) for valid_o.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        op_i = op; data1_i = a; data2_i = b; valid_i = 1'b1;
        step();
        valid_i = 1'b0; op_i = OP_ADD; data1_i = $urandom; data2_i = $urandom;
        lat = 1;
        while (!valid_o && lat < 100) begin
            step();
            lat++;
        end
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_res"}, 64'(res_o), 64'(exp_res));
        step();
    endtask

    initial begin
        int vcnt;
        rst = 1'b1; valid_i = 1'b0; kill_i = 1'b0; op_i = '0; data1_i = '0; data2_i = '0;
        step();
        step();
        chk("rst_ready", 64'(ready_o), 64'd1);
        chk("rst_valid", 64'(valid_o), 64'd0);
        chk("rst_res",   64'(res_o),   64'd0);
        chk("rst_flags", 64'({zero_o, sign_o, ovf_o}), 64'b100);
        rst = 1'b0;
        step();

        run_op("add_ovf", OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1);
        chk("add_flags", 64'({zero_o, sign_o, ovf_o}), 64'b011);
        run_op("sub_zero", OP_SUB, 32'd5, 32'd5, 32'h0, 1);
        chk("sub_flags", 64'({zero_o, sign_o, ovf_o}), 64'b100);
        run_op("sub_ovf", OP_SUB, 32'h8000_0000, 32'h1, 32'h7FFF_FFFF, 1);
        chk("sub_ovf_flags", 64'({zero_o, sign_o, ovf_o}), 64'b001);
        run_op("sra", OP_SRA, 32'h8000_0000, 32'h21, 32'hC000_0000, 1);
        chk("sra_ovf", 64'(ovf_o), 64'd0);
        run_op("srl", OP_SRL, 32'h8000_0000, 32'h4, 32'h0800_0000, 1);
        run_op("sll", OP_SLL, 32'h1, 32'h3F, 32'h8000_0000, 1);
        run_op("slt", OP_SLT, 32'hFFFF_FFFF, 32'h1, 32'h1, 1);
        run_op("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'h1, 32'h0, 1);
        run_op("and", OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1);
        run_op("or", OP_OR, 32'h0000_F0F0, 32'h0000_0F0F, 32'h0000_FFFF, 1);
        run_op("xor", OP_XOR, 32'hFFFF_0000, 32'hFF00_FF00, 32'h00FF_FF00, 1);
        run_op("pass", 5'd31, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_5678, 1);

        run_op("mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 33);
        chk("mulh_flags", 64'({zero_o, sign_o, ovf_o}), 64'b100);
        run_op("mulhu", OP_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mul", OP_MUL, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("divu", OP_DIVU, 32'd100, 32'd7, 32'd14, 33);
        run_op("remu", OP_REMU, 32'd100, 32'd7, 32'd2, 33);
        run_op("divu_z", OP_DIVU, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1);
        run_op("remu_z", OP_REMU, 32'd5, 32'h0, 32'd5, 1);
        run_op("rem_minm1", OP_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1);
        run_op("div_minm1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_op("pass2", 5'd12, 32'h1234_5678, 32'h0, 32'h1234_5678, 1);

        // Kill ten cycles into a divide.
        op_i = OP_DIV; data1_i = 32'd1000; data2_i = 32'd3; valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        repeat (9) step();
        kill_i = 1'b1;
        #1;
        chk("kill_calc_valid", 64'(valid_o), 64'd0);
        step();
        kill_i = 1'b0;
        chk("kill_calc_ready", 64'(ready_o), 64'd1);
        chk("kill_calc_res", 64'(res_o), 64'h1234_5678);
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (valid_o) vcnt++;
        end
        chk("kill_calc_nopulse", 64'(vcnt), 64'd0);

        // Kill in the same cycle as the request cancels it.
        op_i = OP_DIV; data1_i = 32'd9; data2_i = 32'd3; valid_i = 1'b1; kill_i = 1'b1;
        step();
        valid_i = 1'b0; kill_i = 1'b0;
        chk("kill_acc_ready", 64'(ready_o), 64'd1);
        chk("kill_acc_valid", 64'(valid_o), 64'd0);

        // Kill in DONE suppresses the pulse and keeps the old result.
        op_i = OP_ADD; data1_i = 32'd3; data2_i = 32'd4; valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        chk("done_valid", 64'(valid_o), 64'd1);
        kill_i = 1'b1;
        #1;
        chk("kill_done_valid", 64'(valid_o), 64'd0);
        chk("kill_done_res", 64'(res_o), 64'h1234_5678);
        step();
        kill_i = 1'b0;
        chk("kill_done_held", 64'(res_o), 64'h1234_5678);
        chk("kill_done_ready", 64'(ready_o), 64'd1);

        // Reset in the middle of a multiply.
        op_i = OP_MUL; data1_i = 32'd123; data2_i = 32'd456; valid_i = 1'b1;
        step();
        valid_i = 1'b0;
        repeat (5) step();
        chk("mul_busy", 64'(ready_o), 64'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst_mid_ready", 64'(ready_o), 64'd1);
        chk("rst_mid_valid", 64'(valid_o), 64'd0);
        chk("rst_mid_res", 64'(res_o), 64'd0);
        chk("rst_mid_flags", 64'({zero_o, sign_o, ovf_o}), 64'b100);
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (valid_o) vcnt++;
        end
        chk("rst_mid_nopulse", 64'(vcnt), 64'd0);
        run_op("post_rst_add", OP_ADD, 32'd1, 32'd2, 32'd3, 1);

        // Back-to-back ADDs: one accept every two cycles.
        op_i = OP_ADD; data1_i = 32'd10; data2_i = 32'd20; valid_i = 1'b1;
        vcnt = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (valid_o) vcnt++;
        end
        valid_i = 1'b0;
        chk("b2b_pulses", 64'(vcnt), 64'd4);
        chk("b2b_res", 64'(res_o), 64'd30);
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
